// File: rtl/fila_pkg.sv
// Shared types for the fila_param queue/stack buffer and its instantiators.
package fila_pkg;

    typedef enum logic {
        MODE_FIFO = 1'b0,
        MODE_LIFO = 1'b1
    } fila_mode_t;

endpackage : fila_pkg

// File: rtl/fila_edge_detect.sv
// One-bit rising-edge detector; the reset value of the history bit decides
// whether a level already high at reset release counts as an edge.
module fila_edge_detect #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clock_10KHz,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic level_q;

    always_ff @(posedge clock_10KHz or negedge reset) begin
        if (!reset) begin
            level_q <= RST_VAL;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;

endmodule : fila_edge_detect

// File: rtl/fila_param.sv
// WIDTH x DEPTH buffer, FIFO or LIFO at elaboration, driven by edge-triggered
// enqueue/dequeue requests with sticky overflow/underflow and synchronous clear.
module fila_param
    import fila_pkg::*;
#(
    parameter int         WIDTH = 8,
    parameter int         DEPTH = 8,
    parameter fila_mode_t MODE  = MODE_FIFO
) (
    input  logic                       clock_10KHz,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       enqueue_in,
    input  logic                       dequeue_in,
    input  logic                       clear_in,
    output logic [WIDTH-1:0]           data_out,
    output logic                       valid_out,
    output logic [$clog2(DEPTH+1)-1:0] len_out,
    output logic                       full_out,
    output logic                       empty_out,
    output logic                       overflow_out,
    output logic                       underflow_out
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head, tail;
    logic             enq_ev, deq_ev;

    logic [PW-1:0]    nxt_head, nxt_tail, wr_idx, rd_idx;
    logic [LW-1:0]    nxt_len;
    logic [WIDTH-1:0] nxt_data, rd_word;
    logic             nxt_valid, nxt_ovf, nxt_udf, wr_en;

    // Explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    fila_edge_detect #(.RST_VAL(1'b1)) u_enq_edge (
        .clock_10KHz (clock_10KHz),
        .reset       (reset),
        .level       (enqueue_in),
        .rise        (enq_ev)
    );

    fila_edge_detect #(.RST_VAL(1'b1)) u_deq_edge (
        .clock_10KHz (clock_10KHz),
        .reset       (reset),
        .level       (dequeue_in),
        .rise        (deq_ev)
    );

    assign full_out  = (len_out == LW'(DEPTH));
    assign empty_out = (len_out == '0);

    // LIFO uses the occupancy itself as the stack pointer.
    assign wr_idx  = (MODE == MODE_FIFO) ? tail : PW'(len_out);
    assign rd_idx  = (MODE == MODE_FIFO) ? head : PW'(len_out - 1'b1);
    assign rd_word = mem[rd_idx];

    always_comb begin
        nxt_len   = len_out;
        nxt_head  = head;
        nxt_tail  = tail;
        nxt_data  = data_out;
        nxt_valid = 1'b0;
        nxt_ovf   = overflow_out;
        nxt_udf   = underflow_out;
        wr_en     = 1'b0;
        if (clear_in) begin
            nxt_len  = '0;
            nxt_head = '0;
            nxt_tail = '0;
            nxt_data = '0;
            nxt_ovf  = 1'b0;
            nxt_udf  = 1'b0;
        end else if (enq_ev && deq_ev) begin
            nxt_valid = 1'b1;
            if (MODE == MODE_LIFO || empty_out) begin
                nxt_data = data_in;
            end else begin
                // Read old head and write tail together; legal even when full.
                nxt_data = rd_word;
                wr_en    = 1'b1;
                nxt_head = ptr_inc(head);
                nxt_tail = ptr_inc(tail);
            end
        end else if (enq_ev) begin
            if (full_out) begin
                nxt_ovf = 1'b1;
            end else begin
                wr_en   = 1'b1;
                nxt_len = len_out + 1'b1;
                if (MODE == MODE_FIFO) nxt_tail = ptr_inc(tail);
            end
        end else if (deq_ev) begin
            if (empty_out) begin
                nxt_data = '0;
                nxt_udf  = 1'b1;
            end else begin
                nxt_data  = rd_word;
                nxt_valid = 1'b1;
                nxt_len   = len_out - 1'b1;
                if (MODE == MODE_FIFO) nxt_head = ptr_inc(head);
            end
        end
    end

    always_ff @(posedge clock_10KHz or negedge reset) begin
        if (!reset) begin
            len_out       <= '0;
            head          <= '0;
            tail          <= '0;
            data_out      <= '0;
            valid_out     <= 1'b0;
            overflow_out  <= 1'b0;
            underflow_out <= 1'b0;
        end else begin
            len_out       <= nxt_len;
            head          <= nxt_head;
            tail          <= nxt_tail;
            data_out      <= nxt_data;
            valid_out     <= nxt_valid;
            overflow_out  <= nxt_ovf;
            underflow_out <= nxt_udf;
        end
    end

    // Storage is never reset or cleared; occupancy alone defines live entries.
    always_ff @(posedge clock_10KHz) begin
        if (wr_en) mem[wr_idx] <= data_in;
    end

endmodule : fila_param

// File: tb/tb_fila_param.sv
// Directed bench: one FIFO and one LIFO instance, W=8 D=8, with hand-computed expectations.
module tb_fila_param;
    import fila_pkg::*;

    logic       clock_10KHz = 1'b0;
    logic       reset = 1'b0;

    logic [7:0] f_data = '0, l_data = '0;
    logic       f_enq = 1'b0, f_deq = 1'b0, f_clr = 1'b0;
    logic       l_enq = 1'b0, l_deq = 1'b0, l_clr = 1'b0;
    logic [7:0] f_dout, l_dout;
    logic [3:0] f_len, l_len;
    logic       f_valid, f_full, f_empty, f_ovf, f_udf;
    logic       l_valid, l_full, l_empty, l_ovf, l_udf;

    int checks = 0;
    int errors = 0;

    always #50 clock_10KHz = ~clock_10KHz;

    fila_param #(.WIDTH(8), .DEPTH(8), .MODE(MODE_FIFO)) u_fifo (
        .clock_10KHz   (clock_10KHz),
        .reset         (reset),
        .data_in       (f_data),
        .enqueue_in    (f_enq),
        .dequeue_in    (f_deq),
        .clear_in      (f_clr),
        .data_out      (f_dout),
        .valid_out     (f_valid),
        .len_out       (f_len),
        .full_out      (f_full),
        .empty_out     (f_empty),
        .overflow_out  (f_ovf),
        .underflow_out (f_udf)
    );

    fila_param #(.WIDTH(8), .DEPTH(8), .MODE(MODE_LIFO)) u_lifo (
        .clock_10KHz   (clock_10KHz),
        .reset         (reset),
        .data_in       (l_data),
        .enqueue_in    (l_enq),
        .dequeue_in    (l_deq),
        .clear_in      (l_clr),
        .data_out      (l_dout),
        .valid_out     (l_valid),
        .len_out       (l_len),
        .full_out      (l_full),
        .empty_out     (l_empty),
        .overflow_out  (l_ovf),
        .underflow_out (l_udf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock_10KHz);
        #1;
    endtask

    task automatic f_op(input logic e, input logic d, input logic [7:0] v);
        f_enq = e; f_deq = d; f_data = v;
        step();
    endtask

    task automatic f_rel();
        f_enq = 1'b0; f_deq = 1'b0;
        step();
    endtask

    task automatic l_op(input logic e, input logic d, input logic [7:0] v);
        l_enq = e; l_deq = d; l_data = v;
        step();
    endtask

    task automatic l_rel();
        l_enq = 1'b0; l_deq = 1'b0;
        step();
    endtask

    task automatic f_state(input string tag, input logic [7:0] d, input logic v, input logic [3:0] n);
        chk({tag, ".data"}, f_dout, d);
        chk({tag, ".valid"}, f_valid, v);
        chk({tag, ".len"}, f_len, n);
    endtask

    task automatic l_state(input string tag, input logic [7:0] d, input logic v, input logic [3:0] n);
        chk({tag, ".data"}, l_dout, d);
        chk({tag, ".valid"}, l_valid, v);
        chk({tag, ".len"}, l_len, n);
    endtask

    initial begin
        logic [7:0] exp_q [$];

        step();
        step();
        f_state("rst_f", 8'h00, 1'b0, 4'd0);
        chk("rst_f.full", f_full, 1'b0);
        chk("rst_f.empty", f_empty, 1'b1);
        chk("rst_f.ovf", f_ovf, 1'b0);
        chk("rst_f.udf", f_udf, 1'b0);
        l_state("rst_l", 8'h00, 1'b0, 4'd0);
        reset = 1'b1;
        step();

        // FIFO basic order
        f_op(1, 0, 8'h11); f_rel();
        f_op(1, 0, 8'h22); f_rel();
        f_op(1, 0, 8'h33); chk("f_push3.len", f_len, 4'd3); f_rel();
        f_op(0, 1, 8'h00); f_state("f_pop1", 8'h11, 1'b1, 4'd2); f_rel();
        chk("f_pop1.valid_drop", f_valid, 1'b0);
        f_op(0, 1, 8'h00); f_state("f_pop2", 8'h22, 1'b1, 4'd1); f_rel();
        f_op(0, 1, 8'h00); f_state("f_pop3", 8'h33, 1'b1, 4'd0); f_rel();
        chk("f_pop3.empty", f_empty, 1'b1);

        // FIFO empty bypass
        f_op(1, 1, 8'h5A); f_state("f_bypass", 8'h5A, 1'b1, 4'd0);
        chk("f_bypass.udf", f_udf, 1'b0);
        chk("f_bypass.ovf", f_ovf, 1'b0);
        f_rel();

        // FIFO fill, overflow, wrap
        for (int i = 1; i <= 8; i++) begin
            f_op(1, 0, 8'(i)); f_rel();
        end
        chk("f_fill.len", f_len, 4'd8);
        chk("f_fill.full", f_full, 1'b1);
        f_op(1, 0, 8'h99); f_rel();
        chk("f_ovf.flag", f_ovf, 1'b1);
        chk("f_ovf.len", f_len, 4'd8);
        for (int i = 1; i <= 3; i++) begin
            f_op(0, 1, 8'h00); chk("f_wrap_pop", f_dout, 32'(i)); f_rel();
        end
        f_op(1, 0, 8'hA0); f_rel();
        f_op(1, 0, 8'hA1); f_rel();
        f_op(1, 0, 8'hA2); f_rel();
        chk("f_refill.len", f_len, 4'd8);
        f_op(1, 1, 8'h77); f_state("f_full_both", 8'h04, 1'b1, 4'd8); f_rel();
        exp_q = '{8'h05, 8'h06, 8'h07, 8'h08, 8'hA0, 8'hA1, 8'hA2, 8'h77};
        for (int i = 0; i < 8; i++) begin
            f_op(0, 1, 8'h00); chk("f_drain", f_dout, exp_q[i]); f_rel();
        end
        chk("f_drain.empty", f_empty, 1'b1);
        f_op(0, 1, 8'h00); f_state("f_udf", 8'h00, 1'b0, 4'd0); f_rel();
        chk("f_udf.flag", f_udf, 1'b1);
        chk("f_udf.ovf_sticky", f_ovf, 1'b1);

        // Clear with len 5 and both sticky flags set
        for (int i = 0; i < 6; i++) begin
            f_op(1, 0, 8'h31 + 8'(i)); f_rel();
        end
        f_op(0, 1, 8'h00); f_state("f_preclr", 8'h31, 1'b1, 4'd5); f_rel();
        f_clr = 1'b1; step(); f_clr = 1'b0;
        f_state("f_clr", 8'h00, 1'b0, 4'd0);
        chk("f_clr.ovf", f_ovf, 1'b0);
        chk("f_clr.udf", f_udf, 1'b0);
        chk("f_clr.empty", f_empty, 1'b1);
        step();

        // Held request counts once
        f_enq = 1'b1; f_data = 8'h42;
        repeat (10) step();
        chk("f_held.len", f_len, 4'd1);
        f_rel();

        // LIFO
        l_op(1, 0, 8'hA1); l_rel();
        l_op(1, 0, 8'hB2); l_rel();
        l_op(1, 1, 8'h3C); l_state("l_bypass", 8'h3C, 1'b1, 4'd2); l_rel();
        l_op(1, 0, 8'hC3); l_rel();
        chk("l_push.len", l_len, 4'd3);
        l_op(0, 1, 8'h00); l_state("l_pop1", 8'hC3, 1'b1, 4'd2); l_rel();
        l_op(0, 1, 8'h00); l_state("l_pop2", 8'hB2, 1'b1, 4'd1); l_rel();
        l_op(0, 1, 8'h00); l_state("l_pop3", 8'hA1, 1'b1, 4'd0); l_rel();
        chk("l_pop3.udf", l_udf, 1'b0);
        l_op(0, 1, 8'h00); l_state("l_udf", 8'h00, 1'b0, 4'd0); l_rel();
        chk("l_udf.flag", l_udf, 1'b1);

        // Asynchronous reset mid-sequence, request held across release
        chk("pre_rst.len", f_len, 4'd1);
        reset = 1'b0;
        #1;
        f_state("arst_f", 8'h00, 1'b0, 4'd0);
        chk("arst_f.empty", f_empty, 1'b1);
        chk("arst_l.udf", l_udf, 1'b0);
        f_enq = 1'b1; f_data = 8'h66;
        step(); step();
        reset = 1'b1;
        step(); step();
        chk("held_rst.len", f_len, 4'd0);
        f_rel();
        f_op(1, 0, 8'h66); f_rel();
        chk("post_rst.len", f_len, 4'd1);
        f_op(0, 1, 8'h00); f_state("post_rst_pop", 8'h66, 1'b1, 4'd0); f_rel();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fila_param
